// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-controller signal bundle: ID/EX/MEM hazard sources in, stage hold/clear controls and perf counters out.
// master = core pipeline side, slave = hazard_ctrl.
interface hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       reg1_src_ID;
    logic [4:0]       reg2_src_ID;
    logic [4:0]       reg_dst_EX;
    logic             cache_read_en_EX;
    logic             br_taken_EX;
    logic             jalr_EX;
    logic             jal_ID;
    logic             mem_req_MEM;
    logic             miss;

    logic             bubbleF, bubbleD, bubbleE, bubbleM, bubbleW;
    logic             flushF, flushD, flushE, flushM, flushW;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] miss_cnt;
    logic             timeout_err;

    modport master (
        output reg1_src_ID, reg2_src_ID, reg_dst_EX, cache_read_en_EX,
               br_taken_EX, jalr_EX, jal_ID, mem_req_MEM, miss,
        input  bubbleF, bubbleD, bubbleE, bubbleM, bubbleW,
               flushF, flushD, flushE, flushM, flushW,
               stall_cnt, miss_cnt, timeout_err
    );

    modport slave (
        input  reg1_src_ID, reg2_src_ID, reg_dst_EX, cache_read_en_EX,
               br_taken_EX, jalr_EX, jal_ID, mem_req_MEM, miss,
        output bubbleF, bubbleD, bubbleE, bubbleM, bubbleW,
               flushF, flushD, flushE, flushM, flushW,
               stall_cnt, miss_cnt, timeout_err
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32I core: load-use stall, EX/ID redirect flush, D-cache miss freeze.
// Hold/clear controls are combinational (same cycle); counters, watchdog and miss FSM update on clk.
module hazard_ctrl #(
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    hazard_ctrl_if.slave      bus
);
    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic {S_RUN, S_MISS} state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_miss_cnt;
    logic [WD_W-1:0]  r_wd;
    logic             r_timeout_err;

    logic             w_freeze;
    logic             w_redirect;
    logic             w_load_use;
    logic             w_stall_inc;
    logic [WD_W-1:0]  w_wd_inc;
    logic [4:0]       w_bubble;
    logic [4:0]       w_flush;

    // A miss in MISS state freezes regardless of mem_req_MEM; from RUN it needs an active access.
    assign w_freeze   = bus.miss && (r_state == S_MISS || bus.mem_req_MEM);
    assign w_redirect = bus.br_taken_EX || bus.jalr_EX;
    assign w_load_use = bus.cache_read_en_EX && (bus.reg_dst_EX != 5'd0) &&
                        (bus.reg_dst_EX == bus.reg1_src_ID || bus.reg_dst_EX == bus.reg2_src_ID);
    assign w_stall_inc = w_freeze || (w_load_use && !w_redirect);
    assign w_wd_inc    = (r_wd == WD_W'(TIMEOUT)) ? r_wd : r_wd + WD_W'(1);

    // Bit order {F, D, E, M, W}.
    always_comb begin
        w_bubble = 5'b00000;
        w_flush  = 5'b00000;
        if (rst) begin
            w_flush = 5'b11111;
        end else if (w_freeze) begin
            w_bubble = 5'b11111;
        end else if (w_redirect) begin
            w_flush = 5'b01100;
        end else if (w_load_use) begin
            w_bubble = 5'b11000;
            w_flush  = 5'b00100;
        end else if (bus.jal_ID) begin
            w_flush = 5'b01000;
        end
    end

    assign {bus.bubbleF, bus.bubbleD, bus.bubbleE, bus.bubbleM, bus.bubbleW} = w_bubble;
    assign {bus.flushF,  bus.flushD,  bus.flushE,  bus.flushM,  bus.flushW}  = w_flush;
    assign bus.stall_cnt   = r_stall_cnt;
    assign bus.miss_cnt    = r_miss_cnt;
    assign bus.timeout_err = r_timeout_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_RUN;
            r_stall_cnt   <= '0;
            r_miss_cnt    <= '0;
            r_wd          <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_stall_inc) begin
                r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end

            case (r_state)
                S_RUN: begin
                    if (w_freeze) begin
                        r_state    <= S_MISS;
                        r_miss_cnt <= r_miss_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                S_MISS: begin
                    if (!bus.miss) begin
                        r_state <= S_RUN;
                    end
                end
                default: r_state <= S_RUN;
            endcase

            // Watchdog counts every frozen cycle including the entry cycle; cleared once the pipe advances.
            if (w_freeze) begin
                r_wd <= w_wd_inc;
                if (w_wd_inc == WD_W'(TIMEOUT)) begin
                    r_timeout_err <= 1'b1;
                end
            end else begin
                r_wd <= '0;
            end
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic against a per-cycle rule model.
module tb_hazard_ctrl;
    localparam int TO  = 8;
    localparam int CW  = 8;
    localparam int MOD = 1 << CW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(CW)) bus();
    hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: whether the pipe is frozen on a miss, counters, watchdog, sticky error.
    bit m_in_miss;
    int m_stall, m_mcnt, m_wd;
    bit m_err;

    logic [9:0] obs_out, exp_out;
    int         obs_stall, obs_mcnt, exp_stall, exp_mcnt;
    logic       obs_err, exp_err;

    localparam logic [9:0] O_IDLE   = 10'b00000_00000;
    localparam logic [9:0] O_FREEZE = 10'b11111_00000;
    localparam logic [9:0] O_REDIR  = 10'b00000_01100;
    localparam logic [9:0] O_LU     = 10'b11000_00100;
    localparam logic [9:0] O_JAL    = 10'b00000_01000;
    localparam logic [9:0] O_RST    = 10'b00000_11111;

    function automatic bit model_lu();
        return bus.cache_read_en_EX && bus.reg_dst_EX != 0 &&
               (bus.reg_dst_EX == bus.reg1_src_ID || bus.reg_dst_EX == bus.reg2_src_ID);
    endfunction

    function automatic logic [9:0] model_out();
        if (rst) return O_RST;
        if (bus.miss && (m_in_miss || bus.mem_req_MEM)) return O_FREEZE;
        if (bus.br_taken_EX || bus.jalr_EX) return O_REDIR;
        if (model_lu()) return O_LU;
        if (bus.jal_ID) return O_JAL;
        return O_IDLE;
    endfunction

    function automatic logic [9:0] dut_out();
        return {bus.bubbleF, bus.bubbleD, bus.bubbleE, bus.bubbleM, bus.bubbleW,
                bus.flushF,  bus.flushD,  bus.flushE,  bus.flushM,  bus.flushW};
    endfunction

    task automatic model_reset();
        m_in_miss = 0; m_stall = 0; m_mcnt = 0; m_wd = 0; m_err = 0;
    endtask

    task automatic model_step();
        bit frozen;
        if (rst) begin
            model_reset();
            return;
        end
        frozen = bus.miss && (m_in_miss || bus.mem_req_MEM);
        if (frozen) begin
            if (!m_in_miss) m_mcnt = (m_mcnt + 1) % MOD;
            m_in_miss = 1;
            m_stall = (m_stall + 1) % MOD;
            m_wd = (m_wd < TO) ? m_wd + 1 : TO;
            if (m_wd >= TO) m_err = 1;
        end else begin
            m_in_miss = 0;
            m_wd = 0;
            if (model_lu() && !(bus.br_taken_EX || bus.jalr_EX)) m_stall = (m_stall + 1) % MOD;
        end
    endtask

    task automatic set_idle();
        bus.reg1_src_ID = 0; bus.reg2_src_ID = 0; bus.reg_dst_EX = 0;
        bus.cache_read_en_EX = 0; bus.br_taken_EX = 0; bus.jalr_EX = 0;
        bus.jal_ID = 0; bus.mem_req_MEM = 0; bus.miss = 0;
    endtask

    // One cycle: sample DUT and model mid-cycle, then advance both on the edge.
    task automatic tick();
        @(negedge clk);
        obs_out = dut_out(); obs_stall = int'(bus.stall_cnt); obs_mcnt = int'(bus.miss_cnt); obs_err = bus.timeout_err;
        exp_out = model_out(); exp_stall = m_stall; exp_mcnt = m_mcnt; exp_err = m_err;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        set_idle();
        rst = 1'b1;
        #12;
        n_tests++; if (dut_out() !== O_RST) begin n_fail++; $display("FAIL reset_out got %b want %b", dut_out(), O_RST); end
        n_tests++; if (bus.stall_cnt !== 0 || bus.miss_cnt !== 0 || bus.timeout_err !== 0) begin
            n_fail++; $display("FAIL reset_regs got stall=%0d miss=%0d err=%b want 0 0 0", bus.stall_cnt, bus.miss_cnt, bus.timeout_err); end
        @(negedge clk); rst = 1'b0; model_reset();
        @(posedge clk); #1;
    endtask

    task automatic test_load_use();
        bus.cache_read_en_EX = 1; bus.reg_dst_EX = 5; bus.reg1_src_ID = 5; bus.reg2_src_ID = 9;
        tick();
        n_tests++; if (obs_out !== O_LU) begin n_fail++; $display("FAIL lu_out got %b want %b", obs_out, O_LU); end
        n_tests++; if (obs_stall !== 0) begin n_fail++; $display("FAIL lu_stall0 got %0d want 0", obs_stall); end
        bus.cache_read_en_EX = 0;
        tick();
        n_tests++; if (obs_out !== O_IDLE) begin n_fail++; $display("FAIL lu_release got %b want %b", obs_out, O_IDLE); end
        n_tests++; if (obs_stall !== 1) begin n_fail++; $display("FAIL lu_stall1 got %0d want 1", obs_stall); end
        set_idle();
    endtask

    task automatic test_x0_branch();
        int base;
        base = m_stall;
        bus.cache_read_en_EX = 1; bus.reg_dst_EX = 0; bus.reg2_src_ID = 0;
        tick();
        n_tests++; if (obs_out !== O_IDLE) begin n_fail++; $display("FAIL x0_out got %b want %b", obs_out, O_IDLE); end
        bus.reg_dst_EX = 7; bus.reg2_src_ID = 7; bus.br_taken_EX = 1;
        tick();
        n_tests++; if (obs_out !== O_REDIR) begin n_fail++; $display("FAIL br_prio_out got %b want %b", obs_out, O_REDIR); end
        set_idle();
        tick();
        n_tests++; if (obs_stall !== base) begin n_fail++; $display("FAIL br_prio_stall got %0d want %0d", obs_stall, base); end
        bus.jalr_EX = 1; bus.jal_ID = 1;
        tick();
        n_tests++; if (obs_out !== O_REDIR) begin n_fail++; $display("FAIL jalr_out got %b want %b", obs_out, O_REDIR); end
        set_idle();
    endtask

    task automatic test_miss();
        int bs, bm;
        bs = m_stall; bm = m_mcnt;
        bus.mem_req_MEM = 1; bus.miss = 1; bus.jal_ID = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_tests++; if (obs_out !== O_FREEZE) begin n_fail++; $display("FAIL miss_cyc%0d got %b want %b", i, obs_out, O_FREEZE); end
        end
        bus.mem_req_MEM = 0; bus.miss = 0;
        tick();
        n_tests++; if (obs_out !== O_JAL) begin n_fail++; $display("FAIL miss_exit_jal got %b want %b", obs_out, O_JAL); end
        n_tests++; if (obs_mcnt !== (bm + 1) % MOD) begin n_fail++; $display("FAIL miss_cnt got %0d want %0d", obs_mcnt, (bm + 1) % MOD); end
        n_tests++; if (obs_stall !== (bs + 4) % MOD) begin n_fail++; $display("FAIL miss_stall got %0d want %0d", obs_stall, (bs + 4) % MOD); end
        // Back in RUN, a miss without an active access must not freeze.
        bus.jal_ID = 0; bus.miss = 1;
        tick();
        n_tests++; if (obs_out !== O_IDLE) begin n_fail++; $display("FAIL miss_run_probe got %b want %b", obs_out, O_IDLE); end
        set_idle();
    endtask

    task automatic test_back_to_back();
        int bs, bm, adv;
        bs = m_stall; bm = m_mcnt; adv = 0;
        for (int i = 0; i < 6; i++) begin
            bus.mem_req_MEM = 1;
            bus.miss = (i == 2 || i == 5) ? 1'b0 : 1'b1;
            tick();
            if (i < 5 && obs_out[9] === 1'b0) adv++;
            n_tests++; if (obs_out !== exp_out) begin n_fail++; $display("FAIL b2b_cyc%0d got %b want %b", i, obs_out, exp_out); end
        end
        n_tests++; if (adv !== 1) begin n_fail++; $display("FAIL b2b_advance got %0d want 1", adv); end
        set_idle();
        tick();
        n_tests++; if (obs_mcnt !== (bm + 2) % MOD) begin n_fail++; $display("FAIL b2b_miss_cnt got %0d want %0d", obs_mcnt, (bm + 2) % MOD); end
        n_tests++; if (obs_stall !== (bs + 4) % MOD) begin n_fail++; $display("FAIL b2b_stall got %0d want %0d", obs_stall, (bs + 4) % MOD); end
    endtask

    task automatic test_watchdog();
        bus.mem_req_MEM = 1; bus.miss = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_tests++; if (obs_err !== (i >= TO)) begin n_fail++; $display("FAIL wd_cyc%0d got %b want %b", i, obs_err, (i >= TO)); end
        end
        set_idle();
        tick(); tick();
        n_tests++; if (obs_err !== 1'b1) begin n_fail++; $display("FAIL wd_sticky got %b want 1", obs_err); end
        n_tests++; if (obs_out !== O_IDLE) begin n_fail++; $display("FAIL wd_after got %b want %b", obs_out, O_IDLE); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        n_tests++; if (obs_err !== 1'b0) begin n_fail++; $display("FAIL wd_rst_clear got %b want 0", obs_err); end
    endtask

    task automatic test_async_reset();
        bus.mem_req_MEM = 1; bus.miss = 1;
        tick(); tick();
        #2 rst = 1'b1;
        #1;
        n_tests++; if (dut_out() !== O_RST) begin n_fail++; $display("FAIL arst_out got %b want %b", dut_out(), O_RST); end
        n_tests++; if (bus.stall_cnt !== 0 || bus.miss_cnt !== 0) begin
            n_fail++; $display("FAIL arst_cnt got stall=%0d miss=%0d want 0 0", bus.stall_cnt, bus.miss_cnt); end
        model_reset();
        tick();
        n_tests++; if (obs_out !== O_RST) begin n_fail++; $display("FAIL arst_hold got %b want %b", obs_out, O_RST); end
        @(negedge clk); rst = 1'b0; bus.mem_req_MEM = 0;
        @(posedge clk); model_step(); #1;
        tick();
        n_tests++; if (obs_out !== O_IDLE) begin n_fail++; $display("FAIL arst_run_probe got %b want %b", obs_out, O_IDLE); end
        set_idle();
    endtask

    task automatic test_random();
        logic mv;
        mv = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) mv = ~mv;
            bus.miss = mv;
            bus.mem_req_MEM = ($urandom_range(0, 2) != 0);
            bus.reg_dst_EX = 5'($urandom_range(0, 3));
            bus.reg1_src_ID = 5'($urandom_range(0, 3));
            bus.reg2_src_ID = 5'($urandom_range(0, 3));
            bus.cache_read_en_EX = $urandom_range(0, 1);
            bus.br_taken_EX = ($urandom_range(0, 5) == 0);
            bus.jalr_EX = ($urandom_range(0, 9) == 0);
            bus.jal_ID = ($urandom_range(0, 4) == 0);
            tick();
            n_tests++; if (obs_out !== exp_out) begin n_fail++; $display("FAIL rnd_out cyc%0d got %b want %b", i, obs_out, exp_out); end
            n_tests++; if (obs_stall !== exp_stall) begin n_fail++; $display("FAIL rnd_stall cyc%0d got %0d want %0d", i, obs_stall, exp_stall); end
            n_tests++; if (obs_mcnt !== exp_mcnt) begin n_fail++; $display("FAIL rnd_miss_cnt cyc%0d got %0d want %0d", i, obs_mcnt, exp_mcnt); end
            n_tests++; if (obs_err !== exp_err) begin n_fail++; $display("FAIL rnd_err cyc%0d got %b want %b", i, obs_err, exp_err); end
        end
        set_idle();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_load_use();
        test_x0_branch();
        test_miss();
        test_back_to_back();
        test_watchdog();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
